// File: rtl/canvas_pkg.sv
// Shared definitions for the canvas cursor: button indices, colours, status layout, edge stepping.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package canvas_pkg;

    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_LEFT  = 0;

    typedef logic [2:0] color_t;

    localparam color_t BLACK   = 3'b000;
    localparam color_t BLUE    = 3'b001;
    localparam color_t GREEN   = 3'b010;
    localparam color_t CYAN    = 3'b011;
    localparam color_t RED     = 3'b100;
    localparam color_t MAGENTA = 3'b101;
    localparam color_t YELLOW  = 3'b110;
    localparam color_t WHITE   = 3'b111;

    localparam int ST_PX_VALID  = 0;
    localparam int ST_BTN_LSB   = 1;
    localparam int ST_COLOR_LSB = 5;

    // Opposing requests cancel; otherwise step one cell, wrapping or saturating at the edges.
    function automatic int step_pos(input int pos, input logic inc, input logic dec,
                                    input int max_pos, input logic wrap);
        if (inc && !dec)
            return (pos == max_pos) ? (wrap ? 0 : max_pos) : pos + 1;
        if (dec && !inc)
            return (pos == 0) ? (wrap ? max_pos : 0) : pos - 1;
        return pos;
    endfunction

endpackage

// File: rtl/canvas_debounce.sv
// One button: 2-flop synchroniser, inversion and debounce counter producing a level and a press pulse.
// Latency: 2 sync edges + DEBOUNCE_CYCLES edges from a stable raw change to level/rise.
// Backpressure: none; rise is a single-cycle pulse that the consumer may ignore.
module canvas_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          s;

    assign s = ~sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s;
                cnt   <= '0;
                rise  <= s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/canvas_cursor.sv
// Debounced button cursor on a CANVAS_W x CANVAS_H grid issuing one pixel write per move (auto-repeat: CANVAS_AUTOREPEAT_EN).
// Latency: 2 + DEBOUNCE_CYCLES + 1 edges from a stable raw press to cursor update and px_valid.
// Backpressure: single-entry output register; events arriving while px_valid is high are dropped.
module canvas_cursor
    import canvas_pkg::*;
#(
    parameter int CANVAS_W        = 16,
    parameter int CANVAS_H        = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WRAP            = 1,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 8,
    localparam int XW = $clog2(CANVAS_W),
    localparam int YW = $clog2(CANVAS_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    buttons_n,
    input  logic [2:0]    rgb_sel,
    input  logic          brush,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          px_valid,
    input  logic          px_ready,
    output logic [XW-1:0] px_x,
    output logic [YW-1:0] px_y,
    output logic [2:0]    px_color,
    output logic [7:0]    status
);

    logic [3:0]    level;
    logic [3:0]    rise;
    logic [3:0]    rep_ev;
    logic [3:0]    ev;
    logic          take;
    color_t        color_mix;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic [7:0]    status_nxt;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        canvas_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .btn_n (buttons_n[i]),
            .level (level[i]),
            .rise  (rise[i])
        );
    end

`ifdef CANVAS_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [3:0]    lvl_q;
    logic [RW-1:0] rep_cnt;
    logic          rep_phase;
    logic          one_hot;
    logic          changed;
    logic          rep_fire;

    assign one_hot  = (level != 4'b0000) && ((level & (level - 4'd1)) == 4'b0000);
    assign changed  = (level != lvl_q);
    assign rep_fire = one_hot && !changed &&
                      (rep_phase ? (rep_cnt == RW'(REPEAT_PERIOD)) : (rep_cnt == RW'(REPEAT_DELAY)));
    assign rep_ev   = rep_fire ? level : 4'b0000;

    // rep_cnt holds the number of cycles since the last level change or repeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q     <= 4'b0000;
            rep_cnt   <= RW'(1);
            rep_phase <= 1'b0;
        end else begin
            lvl_q <= level;
            if (changed || !one_hot) begin
                rep_cnt   <= RW'(1);
                rep_phase <= 1'b0;
            end else if (rep_fire) begin
                rep_cnt   <= RW'(1);
                rep_phase <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
`else
    // Repeat parameters are inert without the macro.
    localparam bit REPEAT_CFG_OK = (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);
    assign rep_ev = {4{REPEAT_CFG_OK}} & 4'b0000;
`endif

    assign ev        = rise | rep_ev;
    assign take      = (ev != 4'b0000) && !px_valid;
    assign color_mix = brush ? color_t'(rgb_sel) : BLACK;

    always_comb begin
        nx = XW'(step_pos(int'(cur_x), ev[BTN_RIGHT], ev[BTN_LEFT], CANVAS_W - 1, WRAP != 0));
        ny = YW'(step_pos(int'(cur_y), ev[BTN_DOWN], ev[BTN_UP], CANVAS_H - 1, WRAP != 0));
    end

    always_comb begin
        status_nxt                       = '0;
        status_nxt[ST_COLOR_LSB +: 3]    = color_mix;
        status_nxt[ST_BTN_LSB +: 4]      = level;
        status_nxt[ST_PX_VALID]          = px_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x    <= '0;
            cur_y    <= '0;
            px_valid <= 1'b0;
            px_x     <= '0;
            px_y     <= '0;
            px_color <= BLACK;
            status   <= '0;
        end else begin
            status <= status_nxt;
            if (take) begin
                cur_x    <= nx;
                cur_y    <= ny;
                px_x     <= nx;
                px_y     <= ny;
                px_color <= color_mix;
                px_valid <= 1'b1;
            end else if (px_ready) begin
                px_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/canvas_cursor.md
# canvas_cursor

Parametrised successor to the canvas control core: turns raw active-low direction buttons into debounced, edge-detected cursor moves on a `CANVAS_W` x `CANVAS_H` grid. After every move it emits one pixel-write transaction (position plus brush colour, or black when erasing) over a valid/ready handshake. It sits between the TinyTapeout pin wrapper and the pixel store / display driver, and also publishes the 8-bit status word to `uo_out`.

## Interface
Parameters:
- `CANVAS_W`, 16: grid width in pixels, at least 2.
- `CANVAS_H`, 16: grid height in pixels, at least 2.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles needed to accept a level change, at least 1.
- `WRAP`, 1: 1 = wrap at edges; 0 = clamp at edges.
- `REPEAT_DELAY`, 32: hold cycles before the first auto-repeat. Used only with the macro.
- `REPEAT_PERIOD`, 8: cycles between auto-repeats. Used only with the macro.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `buttons_n` in 4: raw active-low buttons `{up, down, right, left}`, asynchronous to `clk`.
- `rgb_sel` in 3: `{R, G, B}` level switches.
- `brush` in 1: 1 = brush, 0 = eraser.
- `cur_x` out XW: cursor X position. XW = `$clog2(CANVAS_W)`.
- `cur_y` out YW: cursor Y position. YW = `$clog2(CANVAS_H)`.
- `px_valid` out 1: a pixel write is pending.
- `px_ready` in 1: the consumer accepts the write.
- `px_x` out XW: X coordinate of the write.
- `px_y` out YW: Y coordinate of the write.
- `px_color` out 3: colour of the write.
- `status` out 8: registered `{color_mix[2:0], btn_level[3:0], px_valid}`.

## Operation
Input synchronisation:
- Each `buttons_n` bit passes through a 2-flop synchroniser and is inverted, giving `s` (1 = pressed).

Debounce, per button:
- State: accepted level `d` and a counter `cnt`.
- If `s == d`: `cnt <= 0`.
- Else, if `cnt == DEBOUNCE_CYCLES-1`: `d <= s` and `cnt <= 0`.
- Else: `cnt <= cnt+1`.
- A press event is a 0->1 transition of `d`.

Move decode, for events in the same cycle:
- up+down together: no Y change.
- right+left together: no X change.
- Orthogonal pairs give a diagonal move.
- Up decrements Y; right increments X.

Edge handling:
- `WRAP=1`: arithmetic is modulo `CANVAS_W` / `CANVAS_H`. Explicit compare, not power-of-2 truncation.
- `WRAP=0`: the position saturates at 0 and at W-1 / H-1.

Pixel writes:
- Any accepted event cycle issues a write at the new (possibly unchanged) position.
- `color_mix = brush ? rgb_sel : 3'b000`, sampled in the event cycle.

Handshake:
- `px_valid` rises with its payload. Payload is held stable until the cycle where `px_valid && px_ready`.
- Events arriving while a write is pending (including the accept cycle) are dropped: the cursor does not move and no write is queued. A single-entry output register is the only buffering.

## Timing
- Reset: `cur_x`/`cur_y` = 0, `px_valid` = 0, `px_x`/`px_y`/`px_color` = 0, `status` = 0, all `d` = 0, all counters 0, synchroniser flops = 1 (released).
- Latency from a stable raw change to `px_valid`/cursor update: 2 + `DEBOUNCE_CYCLES` + 1 clock edges.
- `px_valid` deasserts the edge after acceptance. The earliest next write is one cycle later.
- `status` lags internal state by one cycle.
- Reset mid-transaction drops the pending write with no partial state.

## Configuration
- `CANVAS_AUTOREPEAT_EN` defined:
  - While exactly one direction's `d` stays 1, an extra event fires after `REPEAT_DELAY` cycles, then every `REPEAT_PERIOD` cycles.
  - The repeat timer restarts on any `d` change.
  - Repeat events obey the same drop rule.
- Not defined: one event per press only. Repeat logic and the repeat parameters have no effect.

## Structure
- `canvas_pkg` holds:
  - Button index constants: UP=3, DOWN=2, RIGHT=1, LEFT=0.
  - The `color_t` 3-bit typedef and colour constants (BLACK…WHITE).
  - The status bit-field positions.
- Sub-module `canvas_debounce`: one button, parametrised by `DEBOUNCE_CYCLES`, containing the synchroniser, counter and `d`, and outputting `level` and `rise`. Instantiate it 4 times.

## Test plan
- Reset with `buttons_n`=4'hF -> cur=(0,0), `px_valid`=0, `status`=0.
- W=H=8, `DEBOUNCE_CYCLES`=4, `brush`=1, `rgb_sel`=3'b110, `px_ready`=1, press right -> 7 edges later cur_x=1, `px_valid` high 1 cycle with `px_x`=1, `px_color`=3'b110.
- Right pulled low for only 3 cycles -> no move, no `px_valid`.
- cur_x=7, press right: `WRAP=1` -> cur_x=0; `WRAP=0` -> cur_x stays 7 and the write is still issued at x=7.
- `px_ready`=0, two separate presses of down -> cur_y=1 only and payload stable. Raise `px_ready` -> one accept, `px_valid` drops the next cycle.
- With `CANVAS_AUTOREPEAT_EN`, DELAY=32, PERIOD=8, hold right for 60 cycles after debounce, `px_ready`=1 -> cur_x=1+1+3=5.
